// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle RV64I control sequencer
//
// Purpose: drives the per-cycle enables and mux selects of a multicycle
// RV64I datapath. The datapath has one shared ALU and one unified
// instruction/data memory port. Memory cycles wait on mem_ready.
// An unsupported opcode or branch funct3 parks the FSM in TRAP until reset.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   opcode, funct3                   instruction fields from the IR
//   zero, lt, ltu                    ALU comparison flags
//   mem_ready                        memory handshake completion
//   mem_req, mem_write, adr_src      memory request / direction / address mux
//   ir_write, pc_write, reg_write    register enables
//   alu_src_a, alu_src_b, alu_op     ALU operand muxes and operation class
//   result_src, imm_src              writeback mux, immediate format
//   illegal                          sticky trap flag
//   state_dbg                        current state encoding
//   instret                          retired-instruction count
//
// Optional feature: define PERF_COUNTER_EN to build the 64-bit instret counter.
// Without it, instret is tied to 0.

module multicycle_sequencer #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        zero,
  input  logic        lt,
  input  logic        ltu,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  result_src,
  output logic [2:0]  imm_src,
  output logic        illegal,
  output logic [3:0]  state_dbg,
  output logic [63:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALRADR  = 4'd10,
    S_JAL      = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_RW     = 7'b0111011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_IW     = 7'b0011011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t state_q, state_d;
  logic   taken;

  always_ff @(posedge clk) begin
    if (reset) state_q <= state_t'(RESET_STATE);
    else       state_q <= state_d;
  end

  always_comb begin
    unique case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    illegal    = 1'b0;
    state_dbg  = state_q;

    // Immediate format depends only on the opcode, independent of state.
    case (opcode)
      OP_STORE:         imm_src = 3'b001;
      OP_BRANCH:        imm_src = 3'b010;
      OP_JAL:           imm_src = 3'b011;
      OP_AUIPC, OP_LUI: imm_src = 3'b100;
      default:          imm_src = 3'b000;
    endcase

    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        // PC+4 is computed and committed in the same cycle the fetch lands.
        if (mem_ready) begin
          ir_write   = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          pc_write   = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculative branch/jump target: ALUOut <- OldPC + imm.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R, OP_RW:       state_d = S_EXECR;
          OP_I, OP_IW:       state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALRADR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = taken;
        // funct3 010/011 are not branch encodings.
        state_d   = (funct3[2:1] == 2'b01) ? S_TRAP : S_FETCH;
      end
      S_JALRADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = S_JAL;
      end
      S_JAL: begin
        // PC takes the target in ALUOut while the ALU forms OldPC+4 for the link.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase

    // Reset forces every output low, including mem_req mid-handshake.
    if (reset) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      result_src = 2'b00;
      imm_src    = 3'b000;
      illegal    = 1'b0;
      state_dbg  = 4'd0;
    end
  end

`ifdef PERF_COUNTER_EN
  logic [63:0] instret_q, instret_d;
  logic        retire;

  always_comb begin
    retire    = (state_d == S_FETCH) &&
                ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                 (state_q == S_ALUWB) || (state_q == S_BRANCH));
    instret_d = instret_q + {63'd0, retire};
  end

  always_ff @(posedge clk) begin
    if (reset) instret_q <= 64'd0;
    else       instret_q <= instret_d;
  end

  assign instret = reset ? 64'd0 : instret_q;
`else
  assign instret = 64'd0;
`endif

endmodule
